// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the seven-segment scan controller: segment
// encodings, blank patterns and slot-phase encoding.
package seg_pkg;

    localparam logic [7:0] ANODE_OFF = 8'hFF;
    localparam logic [6:0] SEG_OFF   = 7'h7F;

    // Active-low gfedcba patterns for hex digits 0..F
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // BLANK keeps every anode off at the start of a slot to stop ghosting
    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } slot_phase_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Host-side bus of the scan controller: load port, global enable and the
// display/status outputs. The host drives through master, the controller
// sits on slave.
interface seg_scan_ctrl_if;

    logic [31:0] data_in;
    logic [7:0]  digit_en_in;
    logic        data_ld;
    logic        disp_en;
    logic        pend_busy;
    logic        frame_start;
    logic [7:0]  anode;
    logic [6:0]  cathode;

    modport master (
        output data_in, digit_en_in, data_ld, disp_en,
        input  pend_busy, frame_start, anode, cathode
    );

    modport slave (
        input  data_in, digit_en_in, data_ld, disp_en,
        output pend_busy, frame_start, anode, cathode
    );

endinterface

// File: rtl/seg_scan_ctrl_hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_7seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Straight table lookup, no state
    always_comb begin
        seg = SEG_LUT[nibble];
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Round-robin scan scheduler for a shared 8-digit seven-segment display.
// Each digit gets a slot of TICK_DIV cycles, the first BLANK_CYC of which
// keep all anodes off. Host loads are double-buffered and only become
// visible at the frame boundary so a frame never mixes old and new data.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int TICK_DIV   = 100000,
    parameter int BLANK_CYC  = 1000
) (
    input  logic          clk,
    input  logic          resetmeta,
    seg_scan_ctrl_if.slave bus
);

    localparam int               CNT_W     = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [2:0]       IDX_LAST  = 3'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [31:0]      act_data;
    logic [7:0]       act_en;
    logic [31:0]      pend_data;
    logic [7:0]       pend_en;
    logic             pend_busy;
    logic [7:0]       anode_q;
    logic [6:0]       cathode_q;
    logic             frame_start_q;

    slot_phase_t      phase;
    logic             slot_wrap;
    logic             frame_wrap;
    logic             drive_on;
    logic [6:0]       seg;

    assign slot_wrap  = (cnt == CNT_LAST);
    assign frame_wrap = slot_wrap && (idx == IDX_LAST);

    // Slot phase derived from position inside the current digit slot
    always_comb begin
        phase = (cnt < CNT_BLANK) ? BLANK : DRIVE;
    end

    assign drive_on = (phase == DRIVE) && bus.disp_en && act_en[idx];

    hex_to_7seg u_hex (
        .nibble (act_data[{idx, 2'b00} +: 4]),
        .seg    (seg)
    );

    // Free-running slot counter; digit index steps once per slot wrap
    always_ff @(posedge clk) begin
        if (!resetmeta) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_wrap) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Double buffer: loads go to pending, a load landing on the frame wrap goes straight to active
    always_ff @(posedge clk) begin
        if (!resetmeta) begin
            act_data  <= '0;
            act_en    <= '0;
            pend_data <= '0;
            pend_en   <= '0;
            pend_busy <= 1'b0;
        end else if (frame_wrap) begin
            if (bus.data_ld) begin
                act_data <= bus.data_in;
                act_en   <= bus.digit_en_in;
            end else if (pend_busy) begin
                act_data <= pend_data;
                act_en   <= pend_en;
            end
            pend_busy <= 1'b0;
        end else if (bus.data_ld) begin
            pend_data <= bus.data_in;
            pend_en   <= bus.digit_en_in;
            pend_busy <= 1'b1;
        end
    end

    // Display outputs registered one cycle behind the scan state
    always_ff @(posedge clk) begin
        if (!resetmeta) begin
            anode_q       <= ANODE_OFF;
            cathode_q     <= SEG_OFF;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= (cnt == '0) && (idx == 3'd0);
            if (drive_on) begin
                anode_q   <= ~(8'h01 << idx);
                cathode_q <= seg;
            end else begin
                anode_q   <= ANODE_OFF;
                cathode_q <= SEG_OFF;
            end
        end
    end

    assign bus.anode       = anode_q;
    assign bus.cathode     = cathode_q;
    assign bus.frame_start = frame_start_q;
    assign bus.pend_busy   = pend_busy;

endmodule
